// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the mini CPU datapath.
// Fetches 16-bit instructions over valid/ready, holds them in an IR, and drives
// register file and ALU controls over DECODE/EXECUTE/WRITEBACK. Carries no data.
module cpu_ctrl_fsm #(
  parameter int unsigned DATA_WIDTH = 8,   // must be >= 6
  parameter int unsigned REG_COUNT  = 8,   // only 8 supported (3-bit fields)
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         instr_valid_i,
  input  logic [15:0]                  instr_i,
  output logic                         instr_ready_o,
  output logic [$clog2(REG_COUNT)-1:0] rf_read_addr1_o,
  output logic [$clog2(REG_COUNT)-1:0] rf_read_addr2_o,
  output logic [$clog2(REG_COUNT)-1:0] rf_write_addr_o,
  output logic                         rf_write_en_o,
  output logic [2:0]                   alu_op_o,
  output logic                         alu_src_imm_o,
  output logic [DATA_WIDTH-1:0]        imm_o,
  output logic                         busy_o,
  output logic                         halted_o,
  output logic                         illegal_op_o,
  output logic [CNT_WIDTH-1:0]         instr_count_o
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } state_e;

  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluSub   = 3'd1;
  localparam logic [2:0] AluAnd   = 3'd2;
  localparam logic [2:0] AluOr    = 3'd3;
  localparam logic [2:0] AluXor   = 3'd4;
  localparam logic [2:0] AluPassA = 3'd5;
  localparam logic [2:0] AluPassB = 3'd6;

  state_e               state_q, state_d;
  logic [15:0]          ir_q, ir_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [3:0] op;
  logic       op_halt;
  logic       op_illegal;
  logic       op_writes;
  logic [2:0] dec_alu_op;
  logic       dec_src_imm;
  logic       active;

  assign op         = ir_q[15:12];
  assign op_halt    = (op == 4'hF);
  assign op_illegal = (op >= 4'h9) && (op <= 4'hE);
  assign op_writes  = (op >= 4'h1) && (op <= 4'h8);
  assign active     = (state_q == StDecode) || (state_q == StExecute) ||
                      (state_q == StWriteback);

  // State, IR and retired-instruction counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; IR loads only on a completed fetch handshake.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        if (instr_valid_i) begin
          ir_d    = instr_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op_halt)         state_d = StHalt;
        else if (op_illegal) state_d = StFetch;
        else                 state_d = StExecute;
      end
      StExecute: begin
        state_d = StWriteback;
      end
      StWriteback: begin
        state_d = StFetch;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
      StHalt: begin
        if (start_i) state_d = StFetch;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Opcode to ALU control decode.
  always_comb begin
    dec_alu_op  = AluAdd;
    dec_src_imm = 1'b0;
    case (op)
      4'h1: dec_alu_op = AluAdd;
      4'h2: dec_alu_op = AluSub;
      4'h3: dec_alu_op = AluAnd;
      4'h4: dec_alu_op = AluOr;
      4'h5: dec_alu_op = AluXor;
      4'h6: begin
        dec_alu_op  = AluAdd;
        dec_src_imm = 1'b1;
      end
      4'h7: begin
        dec_alu_op  = AluPassB;
        dec_src_imm = 1'b1;
      end
      4'h8:    dec_alu_op = AluPassA;
      default: dec_alu_op = AluAdd;
    endcase
  end

  // Datapath controls are held from DECODE through WRITEBACK and zero elsewhere;
  // write enable follows state_q so reset removes it without waiting for an edge.
  always_comb begin
    rf_read_addr1_o = '0;
    rf_read_addr2_o = '0;
    rf_write_addr_o = '0;
    alu_op_o        = AluAdd;
    alu_src_imm_o   = 1'b0;
    imm_o           = '0;
    if (active) begin
      rf_read_addr1_o = ir_q[8:6];
      rf_read_addr2_o = ir_q[5:3];
      rf_write_addr_o = ir_q[11:9];
      alu_op_o        = dec_alu_op;
      alu_src_imm_o   = dec_src_imm;
      imm_o           = DATA_WIDTH'(ir_q[5:0]);
    end
  end

  assign instr_ready_o = (state_q == StFetch);
  assign rf_write_en_o = (state_q == StWriteback) && op_writes;
  assign busy_o        = (state_q != StIdle) && (state_q != StHalt);
  assign halted_o      = (state_q == StHalt);
  assign illegal_op_o  = (state_q == StDecode) && op_illegal;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: a small register file + ALU in the bench consumes the
// controller's strobes; an instruction-level model predicts each write.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [2:0]  raddr1, raddr2, waddr;
  logic        wen;
  logic [2:0]  alu_op;
  logic        src_imm;
  logic [7:0]  imm;
  logic        busy, halted, illegal;
  logic [15:0] count;

  logic        start2 = 1'b0;
  logic        instr_ready2, wen2, src_imm2, busy2, halted2, illegal2;
  logic [2:0]  raddr1_2, raddr2_2, waddr_2, alu_op2;
  logic [7:0]  imm2;
  logic [3:0]  count2;

  always #5 clk = ~clk;

  cpu_ctrl_fsm u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .instr_valid_i(instr_valid), .instr_i(instr),
    .instr_ready_o(instr_ready), .rf_read_addr1_o(raddr1), .rf_read_addr2_o(raddr2),
    .rf_write_addr_o(waddr), .rf_write_en_o(wen), .alu_op_o(alu_op), .alu_src_imm_o(src_imm),
    .imm_o(imm), .busy_o(busy), .halted_o(halted), .illegal_op_o(illegal),
    .instr_count_o(count)
  );

  // Free-running NOP stream for the narrow-counter wrap check.
  cpu_ctrl_fsm #(.CNT_WIDTH(4)) u_dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .instr_valid_i(1'b1), .instr_i(16'h0000),
    .instr_ready_o(instr_ready2), .rf_read_addr1_o(raddr1_2), .rf_read_addr2_o(raddr2_2),
    .rf_write_addr_o(waddr_2), .rf_write_en_o(wen2), .alu_op_o(alu_op2),
    .alu_src_imm_o(src_imm2), .imm_o(imm2), .busy_o(busy2), .halted_o(halted2),
    .illegal_op_o(illegal2), .instr_count_o(count2)
  );

  // Bench datapath driven purely by the controller outputs.
  logic [7:0] dp_rf [8] = '{default: 8'h00};
  logic [7:0] dp_a, dp_b, dp_res;
  always_comb begin
    dp_a = dp_rf[raddr1];
    dp_b = src_imm ? imm : dp_rf[raddr2];
    case (alu_op)
      3'd0:    dp_res = dp_a + dp_b;
      3'd1:    dp_res = dp_a - dp_b;
      3'd2:    dp_res = dp_a & dp_b;
      3'd3:    dp_res = dp_a | dp_b;
      3'd4:    dp_res = dp_a ^ dp_b;
      3'd5:    dp_res = dp_a;
      3'd6:    dp_res = dp_b;
      default: dp_res = 8'h00;
    endcase
  end
  always @(posedge clk) if (wen) dp_rf[waddr] <= dp_res;

  int wen_cycles = 0;
  always @(negedge clk) if (wen) wen_cycles <= wen_cycles + 1;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level architectural model.
  logic [7:0] arch_rf [8] = '{default: 8'h00};
  int m_count = 0;

  task automatic model(input logic [15:0] ins, output bit m_wen, output logic [2:0] m_a,
                       output logic [7:0] m_d, output bit m_ill);
    int a, b, r;
    a = arch_rf[ins[8:6]];
    b = arch_rf[ins[5:3]];
    r = 0;
    m_wen = 1'b1;
    m_ill = 1'b0;
    m_a   = ins[11:9];
    case (ins[15:12])
      4'h1: r = a + b;
      4'h2: r = a - b;
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = a + int'(ins[5:0]);
      4'h7: r = int'(ins[5:0]);
      4'h8: r = a;
      4'h0: m_wen = 1'b0;
      default: begin
        m_wen = 1'b0;
        m_ill = 1'b1;
      end
    endcase
    m_d = r[7:0];
    if (m_wen) arch_rf[m_a] = m_d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    ok = instr_ready;
    if (!ok) chk("ready_timeout", 32'(instr_ready), 32'd1);
  endtask

  // Issue one non-HALT instruction and check it through to retirement.
  task automatic exec(input logic [15:0] ins, input bit e_wen, input logic [2:0] e_a,
                      input logic [7:0] e_d, input bit e_ill, input bit garb, input int stall);
    bit ok;
    int w0;
    wait_ready(ok);
    if (!ok) return;
    for (int i = 0; i < stall; i++) begin
      instr = 16'($urandom);
      tick();
      chk("stall_ready", 32'(instr_ready), 32'd1);
    end
    w0 = wen_cycles;
    instr_valid = 1'b1;
    instr = ins;
    tick();
    if (garb && !e_ill) begin
      instr = 16'($urandom);
      start = 1'($urandom);
    end else begin
      instr_valid = 1'b0;
    end
    chk("decode_illegal", 32'(illegal), 32'(e_ill));
    chk("decode_busy", 32'(busy), 32'd1);
    if (e_ill) begin
      tick();
      chk("illegal_back_fetch", 32'(instr_ready), 32'd1);
      chk("illegal_count", 32'(count), 32'(16'(m_count)));
      chk("illegal_no_write", 32'(wen_cycles - w0), 32'd0);
      return;
    end
    tick();
    chk("exec_wen", 32'(wen), 32'd0);
    tick();
    chk("wb_wen", 32'(wen), 32'(e_wen));
    if (e_wen) begin
      chk("wb_addr", 32'(waddr), 32'(e_a));
      chk("wb_data", 32'(dp_res), 32'(e_d));
    end
    instr_valid = 1'b0;
    start = 1'b0;
    tick();
    m_count++;
    chk("retire_count", 32'(count), 32'(16'(m_count)));
    chk("retire_ready", 32'(instr_ready), 32'd1);
    chk("one_strobe", 32'(wen_cycles - w0), 32'(e_wen));
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_ctl"}, {4'h0, raddr1, raddr2, waddr, alu_op, src_imm, imm, wen, illegal},
        32'd0);
  endtask

  typedef struct {
    logic [15:0] ins;
    bit          wen;
    logic [2:0]  a;
    logic [7:0]  d;
    bit          ill;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit         ok, m_wen, m_ill;
    logic [2:0] m_a;
    logic [7:0] m_d, saved;
    logic [15:0] ins;

    vecs[0]  = '{16'h7205, 1'b1, 3'd1, 8'd5,  1'b0};  // LI r1,5
    vecs[1]  = '{16'h7403, 1'b1, 3'd2, 8'd3,  1'b0};  // LI r2,3
    vecs[2]  = '{16'h1650, 1'b1, 3'd3, 8'd8,  1'b0};  // ADD r3,r1,r2
    vecs[3]  = '{16'h2850, 1'b1, 3'd4, 8'd2,  1'b0};  // SUB r4,r1,r2
    vecs[4]  = '{16'h3A50, 1'b1, 3'd5, 8'd1,  1'b0};  // AND r5,r1,r2
    vecs[5]  = '{16'h4C50, 1'b1, 3'd6, 8'd7,  1'b0};  // OR  r6,r1,r2
    vecs[6]  = '{16'h5E50, 1'b1, 3'd7, 8'd6,  1'b0};  // XOR r7,r1,r2
    vecs[7]  = '{16'h604A, 1'b1, 3'd0, 8'd15, 1'b0};  // ADDI r0,r1,10
    vecs[8]  = '{16'h84C0, 1'b1, 3'd2, 8'd8,  1'b0};  // MOV r2,r3
    vecs[9]  = '{16'hA000, 1'b0, 3'd0, 8'd0,  1'b1};  // illegal
    vecs[10] = '{16'h0000, 1'b0, 3'd0, 8'd0,  1'b0};  // NOP
    vecs[11] = '{16'h2288, 1'b1, 3'd1, 8'd3,  1'b0};  // SUB r1,r2,r1 (8-5)

    #2;
    check_idle_outputs("reset");
    chk("reset_state", {29'd0, instr_ready, busy, halted}, 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_hold", {30'd0, instr_ready, busy}, 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_fetch", {30'd0, instr_ready, busy}, 32'd3);
    check_idle_outputs("fetch");

    for (int i = 0; i < 12; i++) begin
      model(vecs[i].ins, m_wen, m_a, m_d, m_ill);
      exec(vecs[i].ins, vecs[i].wen, vecs[i].a, vecs[i].d, vecs[i].ill, 1'b0, 0);
    end

    // Long stall in FETCH with instr wiggling, then accept LI r6,9.
    exec(16'h7C09, 1'b1, 3'd6, 8'd9, 1'b0, 1'b1, 5);
    model(16'h7C09, m_wen, m_a, m_d, m_ill);

    // HALT: start/instr_valid pulses inside HALT are ignored except start.
    wait_ready(ok);
    instr_valid = 1'b1;
    instr = 16'hF000;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("halt_state", {29'd0, halted, busy, instr_ready}, 32'd4);
    check_idle_outputs("halt");
    instr_valid = 1'b1;
    instr = 16'h7201;
    repeat (3) tick();
    instr_valid = 1'b0;
    chk("halt_hold", {29'd0, halted, busy, instr_ready}, 32'd4);
    chk("halt_count", 32'(count), 32'(16'(m_count)));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_exit", {29'd0, halted, busy, instr_ready}, 32'd3);
    exec(16'h7A21, 1'b1, 3'd5, 8'd33, 1'b0, 1'b0, 0);
    model(16'h7A21, m_wen, m_a, m_d, m_ill);

    // Reset during WRITEBACK of ADD r3,r1,r2 must kill the write strobe at once.
    wait_ready(ok);
    saved = dp_rf[3];
    instr_valid = 1'b1;
    instr = 16'h1650;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_wen", 32'(wen), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_wen_drop", 32'(wen), 32'd0);
    tick();
    chk("reset_no_write", 32'(dp_rf[3]), 32'(saved));
    check_idle_outputs("mid_reset");
    chk("mid_reset_count", 32'(count), 32'd0);
    rst = 1'b0;
    m_count = 0;
    tick();
    chk("post_reset_state", {29'd0, halted, busy, instr_ready}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;

    // Random instruction stream against the architectural model.
    for (int i = 0; i < 150; i++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 14));
      model(ins, m_wen, m_a, m_d, m_ill);
      exec(ins, m_wen, m_a, m_d, m_ill, 1'($urandom), int'($urandom_range(0, 2)));
    end
    for (int r = 0; r < 8; r++) chk("final_rf", 32'(dp_rf[r]), 32'(arch_rf[r]));

    // 4-bit counter wraps after 16 retirements.
    chk("wrap_start", 32'(count2), 32'd0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      repeat (4) tick();
      chk("wrap_count", 32'(count2), 32'(k % 16));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
